inst_mem_loader: RTL

Boot-time writer for the CPU instruction store. Accepts a big-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. Holds the CPU fetch/PC logic in stall until the program is fully loaded. Flags malformed or oversized programs and refuses further input after any error.

---
 rtl/inst_mem_loader_if.sv | 30 +++
 rtl/inst_mem_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-store write port of the boot loader.
//
// Handshake: a byte (with its in_last flag) transfers on a posedge where
// in_valid && in_ready. The host holds in_valid/in_byte/in_last stable until
// that edge. in_ready depends on loader state only and never on in_valid.
// wr_en is a single-cycle strobe; wr_addr/wr_data are meaningful only while
// it is high.
interface inst_mem_loader_if #(
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_last;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   // Host side: produces the byte stream and observes the store writes.
   modport master (
      output in_valid, in_byte, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   // Loader side.
   modport slave (
      input  in_valid, in_byte, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction store writer: assembles big-endian bytes into 32-bit
// words, writes them to consecutive addresses from 0, holds the CPU until the
// program is loaded, and latches an error on partial words or overflow.
// DEPTH is expected to equal 2**ADDR_W.
module inst_mem_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   inst_mem_loader_if.slave  bus,
   output logic [ADDR_W:0]   word_count,
   output logic              load_done,
   output logic              load_err,
   output logic              cpu_hold,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [1:0]        r_byte_idx;
   logic [ADDR_W-1:0] r_word_ptr;
   logic [ADDR_W:0]   r_word_count;
   logic [31:0]       r_asm;
   logic              r_last_q;
   logic              w_in_ready;
   logic              w_wr_en;
   logic              w_partial_last;

   // in_last on any byte but the 4th of a word is a malformed program.
   assign w_partial_last = bus.in_last && (r_byte_idx != 2'd3);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake/strobe decode.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_wr_en      = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               if (w_partial_last) begin
                  w_next_state = S_ERR;
               end else if (r_byte_idx == 2'd3) begin
                  w_next_state = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            w_wr_en = 1'b1;
            if (r_last_q) begin
               w_next_state = S_DONE;
            end else if (r_word_ptr == LAST_ADDR) begin
               // Store is full and the stream says more is coming.
               w_next_state = S_ERR;
            end else begin
               w_next_state = S_LOAD;
            end
         end
         S_DONE:  w_next_state = S_DONE;
         S_ERR:   w_next_state = S_ERR;
         default: w_next_state = S_ERR;
      endcase
   end

   // Byte assembly, word pointer and word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_idx   <= 2'd0;
         r_word_ptr   <= '0;
         r_word_count <= '0;
         r_asm        <= '0;
         r_last_q     <= 1'b0;
      end else begin
         if (r_state == S_LOAD && bus.in_valid && !w_partial_last) begin
            r_asm      <= {r_asm[23:0], bus.in_byte};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
               r_last_q <= bus.in_last;
            end
         end
         if (r_state == S_WRITE) begin
            r_byte_idx   <= 2'd0;
            r_word_count <= r_word_count + 1'b1;
            // Hold at the top address so the pointer never wraps on overflow.
            if (r_word_ptr != LAST_ADDR) begin
               r_word_ptr <= r_word_ptr + 1'b1;
            end
         end
      end
   end

   // A write pending in the reset cycle is dropped so the store is untouched.
   assign bus.in_ready = w_in_ready;
   assign bus.wr_en    = w_wr_en && !rst;
   assign bus.wr_addr  = r_word_ptr;
   assign bus.wr_data  = r_asm;

   assign word_count = r_word_count;
   assign load_done  = (r_state == S_DONE);
   assign load_err   = (r_state == S_ERR);
   assign cpu_hold   = (r_state != S_DONE);
   assign dbg_state  = r_state;

endmodule
